alu_rr_mchan: RTL and testbench

Parametrised M-channel successor of the two-operation ALU chain. Each channel submits a triple (a, b, c) with two opcodes and receives z = alu(op2, alu(op1, a, b), c). One shared two-stage ALU pipeline serves all channels through a round-robin arbiter, replacing fixed two-channel clock-doubled time-multiplexing with a valid/ready handshake on a single clock. It sits between the operand sequencer and the result collectors.

---
 rtl/alu_rr_mchan.sv | 162 ++++++++++++++++
 tb/tb_alu_rr_mchan.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_mchan.sv
// alu_rr_mchan: M-channel two-op ALU chain (z = op2(op1(a,b),c))
// sharing one two-stage pipeline behind a round-robin arbiter.
module alu_rr_mchan #(
  parameter int N   = 8,
  parameter int OPN = 3,
  parameter int M   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [M-1:0]     in_valid,
  output logic [M-1:0]     in_ready,
  input  logic [M*N-1:0]   a,
  input  logic [M*N-1:0]   b,
  input  logic [M*N-1:0]   c,
  input  logic [M*OPN-1:0] op1,
  input  logic [M*OPN-1:0] op2,
  output logic [M-1:0]     out_valid,
  output logic [M*N-1:0]   z
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (M > 1) ? $clog2(M) : 1;

  typedef struct packed {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [N-1:0]   c;
    logic [OPN-1:0] op1;
    logic [OPN-1:0] op2;
  } req_t;

  typedef struct packed {
    logic           v;
    logic [PW-1:0]  ch;
    logic [N-1:0]   q;
    logic [N-1:0]   c;
    logic [OPN-1:0] op2;
  } s1_t;

  function automatic logic [N-1:0] alu(
    input logic [OPN-1:0] op,
    input logic [N-1:0]   x,
    input logic [N-1:0]   y
  );
    logic [SW-1:0] sh;
    logic [N-1:0]  r;
    sh = y[SW-1:0];
    case (32'(op))
      0:       r = x + y;
      1:       r = x - y;
      2:       r = x & y;
      3:       r = x | y;
      4:       r = x ^ y;
      5:       r = x;
      6:       r = x << sh;
      7:       r = x >> sh;
      default: r = '0;
    endcase
    return r;
  endfunction

  req_t          req_in [M];
  req_t          hold_q [M];
  logic [M-1:0]  pend_q;
  logic [PW-1:0] ptr_q;
  logic [M-1:0]  grant;
  logic [M-1:0]  acc;
  logic [PW-1:0] gidx;
  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] ptr_nxt;
  s1_t           s1_q;
  logic [N-1:0]  z_q [M];

  // Slice the flat operand buses into per-channel requests
  always_comb begin
    for (int i = 0; i < M; i++) begin
      req_in[i].a   = a[i*N +: N];
      req_in[i].b   = b[i*N +: N];
      req_in[i].c   = c[i*N +: N];
      req_in[i].op1 = op1[i*OPN +: OPN];
      req_in[i].op2 = op2[i*OPN +: OPN];
    end
  end

  // First pending channel at or after ptr, wrapping upward
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    sum   = '0;
    grant = '0;
    for (int k = 0; k < M; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(M))
        sum = sum - (PW+1)'(M);
      if (!found && pend_q[sum[PW-1:0]]) begin
        found = 1'b1;
        gidx  = sum[PW-1:0];
      end
    end
    if (found)
      grant[gidx] = 1'b1;
  end

  assign ptr_nxt  = (gidx == PW'(M-1)) ? '0 : gidx + 1'b1;
  assign in_ready = ~pend_q | grant;
  assign acc      = in_valid & in_ready;

  // Holding registers, pending bits and arbiter pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      ptr_q  <= '0;
      for (int i = 0; i < M; i++)
        hold_q[i] <= '0;
    end else begin
      pend_q <= (pend_q & ~grant) | acc;
      if (found)
        ptr_q <= ptr_nxt;
      for (int i = 0; i < M; i++)
        if (acc[i])
          hold_q[i] <= req_in[i];
    end
  end

  // Stage 1: first ALU op on the granted entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else begin
      s1_q.v <= found;
      if (found) begin
        s1_q.ch  <= gidx;
        s1_q.q   <= alu(hold_q[gidx].op1,
                        hold_q[gidx].a,
                        hold_q[gidx].b);
        s1_q.c   <= hold_q[gidx].c;
        s1_q.op2 <= hold_q[gidx].op2;
      end
    end
  end

  // Stage 2: second ALU op, per-channel result and pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      for (int i = 0; i < M; i++)
        z_q[i] <= '0;
    end else begin
      out_valid <= '0;
      if (s1_q.v) begin
        out_valid[s1_q.ch] <= 1'b1;
        z_q[s1_q.ch] <= alu(s1_q.op2, s1_q.q, s1_q.c);
      end
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_z
    assign z[i*N +: N] = z_q[i];
  end

endmodule

// File: tb/tb_alu_rr_mchan.sv
// tb_alu_rr_mchan: randomized and directed bench for
// alu_rr_mchan against a cycle-level behavioural model.
module tb_alu_rr_mchan;

  localparam int N   = 8;
  localparam int OPN = 3;
  localparam int M   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [M-1:0]     in_valid = '0;
  logic [M-1:0]     in_ready;
  logic [M*N-1:0]   a = '0, b = '0, c = '0;
  logic [M*OPN-1:0] op1 = '0, op2 = '0;
  logic [M-1:0]     out_valid;
  logic [M*N-1:0]   z;

  logic       iv2 = 1'b0;
  logic       ir2, ov2;
  logic [7:0] a2 = '0, b2 = '0, c2 = '0, z2;
  logic [3:0] p1 = '0, p2 = '0;

  always #5 clk = ~clk;

  alu_rr_mchan #(.N(N), .OPN(OPN), .M(M)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .op1(op1), .op2(op2),
    .out_valid(out_valid), .z(z)
  );

  alu_rr_mchan #(.N(8), .OPN(4), .M(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv2), .in_ready(ir2),
    .a(a2), .b(b2), .c(c2), .op1(p1), .op2(p2),
    .out_valid(ov2), .z(z2)
  );

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h want %0h",
               nm, cyc_n, act, exp);
    end
  endtask

  function automatic int alu_m(int op, int x, int y);
    logic [31:0] r;
    case (op)
      0: r = x + y;
      1: r = x - y;
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = x;
      6: r = x << (y % N);
      7: r = x >> (y % N);
      default: r = 0;
    endcase
    return int'(r[N-1:0]);
  endfunction

  // model: pending entries, pointer, results in flight
  int           mp [M];
  int           ma [M], mb [M], mc [M];
  int           mo1 [M], mo2 [M];
  int           mptr;
  int           d_v, d_ch, d_z;
  logic [M-1:0] e_ov, e_rdy;
  logic [N-1:0] e_z [M];

  function automatic int pick();
    for (int k = 0; k < M; k++)
      if (mp[(mptr + k) % M] != 0)
        return (mptr + k) % M;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < M; i++) begin
      mp[i]  = 0;
      e_z[i] = '0;
    end
    mptr  = 0;
    d_v   = 0;
    e_ov  = '0;
    e_rdy = '1;
  endtask

  task automatic model_step();
    int g, g2;
    if (!rst_n) begin
      model_reset();
      return;
    end
    g = pick();
    e_ov = '0;
    if (d_v != 0) begin
      e_ov[d_ch] = 1'b1;
      e_z[d_ch]  = N'(d_z);
    end
    d_v = 0;
    if (g >= 0) begin
      d_v  = 1;
      d_ch = g;
      d_z  = alu_m(mo2[g],
                   alu_m(mo1[g], ma[g], mb[g]), mc[g]);
    end
    for (int i = 0; i < M; i++) begin
      if (i == g)
        mp[i] = 0;
      if (in_valid[i] && (mp[i] == 0 || i == g)) begin
        mp[i]  = 1;
        ma[i]  = int'(a[i*N +: N]);
        mb[i]  = int'(b[i*N +: N]);
        mc[i]  = int'(c[i*N +: N]);
        mo1[i] = int'(op1[i*OPN +: OPN]);
        mo2[i] = int'(op2[i*OPN +: OPN]);
      end
    end
    if (g >= 0)
      mptr = (g + 1) % M;
    g2 = pick();
    for (int i = 0; i < M; i++)
      e_rdy[i] = (mp[i] == 0) || (i == g2);
  endtask

  function automatic logic [M*N-1:0] zpack();
    logic [M*N-1:0] r;
    for (int i = 0; i < M; i++)
      r[i*N +: N] = e_z[i];
    return r;
  endfunction

  task automatic compare();
    chk("in_ready", 64'(in_ready), 64'(e_rdy));
    chk("out_valid", 64'(out_valid), 64'(e_ov));
    chk("z", 64'(z), 64'(zpack()));
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    cyc_n++;
    compare();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = '0;
    model_reset();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic rnd_ch(input int i);
    a[i*N +: N]     = N'($urandom);
    b[i*N +: N]     = N'($urandom);
    c[i*N +: N]     = N'($urandom);
    op1[i*OPN +: OPN] = OPN'($urandom);
    op2[i*OPN +: OPN] = OPN'($urandom);
  endtask

  task automatic set_ch(input int i, input int va,
                        input int vb, input int o1,
                        input int vc, input int o2);
    a[i*N +: N]       = N'(va);
    b[i*N +: N]       = N'(vb);
    c[i*N +: N]       = N'(vc);
    op1[i*OPN +: OPN] = OPN'(o1);
    op2[i*OPN +: OPN] = OPN'(o2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle %0d", cyc_n);
    $fatal(1);
  end

  int pulses;
  int va2 [10], vb2 [10], vc2 [10];
  int q1 [10], q2 [10], vz [10];

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_z", 64'(z), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(4'hF));
    do_reset();

    // single request, 2-edge latency
    set_ch(0, 3, 5, 0, 2, 6);
    in_valid = 4'b0001;
    cyc();
    in_valid = '0;
    cyc();
    chk("t1_early", 64'(out_valid), 64'(0));
    cyc();
    chk("t1_ov", 64'(out_valid), 64'(4'b0001));
    chk("t1_z", 64'(z[7:0]), 64'(8'h20));
    cyc();
    chk("t1_pulse_end", 64'(out_valid), 64'(0));

    // all channels at once
    do_reset();
    for (int i = 0; i < M; i++) rnd_ch(i);
    in_valid = '1;
    cyc();
    in_valid = '0;
    chk("t2_rdy", 64'(in_ready), 64'(4'b0001));
    cyc();
    for (int k = 0; k < M; k++) begin
      cyc();
      chk("t2_order", 64'(out_valid), 64'(1 << k));
    end
    rnd_ch(0);
    rnd_ch(3);
    in_valid = 4'b1001;
    cyc();
    in_valid = '0;
    cyc();
    cyc();
    chk("t2_ptr0", 64'(out_valid), 64'(4'b0001));
    cyc();
    chk("t2_ptr3", 64'(out_valid), 64'(4'b1000));

    // fairness between channels 0 and 3
    do_reset();
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      rnd_ch(0);
      rnd_ch(3);
      in_valid = 4'b1001;
      cyc();
      if (out_valid[1] || out_valid[2]) pulses++;
      if (k >= 2)
        chk("t3_alt", 64'(out_valid),
            64'((k % 2 == 0) ? 4'b0001 : 4'b1000));
    end
    in_valid = '0;
    repeat (4) cyc();
    chk("t3_idle_ch", 64'(pulses), 64'(0));

    // wrap-around arithmetic
    do_reset();
    set_ch(1, 0, 1, 1, 2, 0);
    in_valid = 4'b0010;
    cyc();
    in_valid = '0;
    cyc();
    cyc();
    chk("t4_sub_wrap", 64'(z[15:8]), 64'(8'h01));
    set_ch(2, 8'h81, 9, 6, 0, 5);
    in_valid = 4'b0100;
    cyc();
    in_valid = '0;
    cyc();
    cyc();
    chk("t4_shl", 64'(z[23:16]), 64'(8'h02));
    chk("t4_hold", 64'(z[15:8]), 64'(8'h01));

    // reset with entries pending and stage 1 busy
    set_ch(2, 5, 0, 5, 0, 5);
    in_valid = 4'b0100;
    cyc();
    in_valid = '0;
    cyc();
    cyc();
    for (int i = 0; i < M; i++) rnd_ch(i);
    in_valid = '1;
    cyc();
    in_valid = '0;
    cyc();
    rst_n = 1'b0;
    #1;
    chk("t5_ov", 64'(out_valid), 64'(0));
    chk("t5_z", 64'(z), 64'(0));
    chk("t5_rdy", 64'(in_ready), 64'(4'hF));
    model_reset();
    in_valid = '1;
    cyc();
    cyc();
    in_valid = '0;
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (out_valid != '0) pulses++;
    end
    chk("t5_no_ghost", 64'(pulses), 64'(0));
    set_ch(1, 7, 2, 0, 1, 1);
    in_valid = 4'b0010;
    cyc();
    in_valid = '0;
    cyc();
    cyc();
    chk("t5_fresh_ov", 64'(out_valid), 64'(4'b0010));
    chk("t5_fresh_z", 64'(z[15:8]), 64'(8'h08));

    // randomized traffic at varying load
    do_reset();
    for (int k = 0; k < 400; k++) begin
      int dens;
      dens = (k / 50) % 4;
      for (int i = 0; i < M; i++) begin
        rnd_ch(i);
        in_valid[i] = ($urandom_range(3) < dens) ||
                      (dens == 3);
      end
      if (k % 97 == 50) begin
        rst_n = 1'b0;
        #1;
        chk("rnd_rst_ov", 64'(out_valid), 64'(0));
        model_reset();
        cyc();
        rst_n = 1'b1;
      end else begin
        cyc();
      end
    end
    in_valid = '0;
    repeat (6) cyc();

    // M=1, OPN=4: out-of-range opcode and back-to-back
    for (int k = 0; k < 8; k++) begin
      va2[k] = int'($urandom_range(255));
      vb2[k] = int'($urandom_range(255));
      vc2[k] = int'($urandom_range(255));
      q1[k]  = int'($urandom_range(15));
      q2[k]  = int'($urandom_range(15));
    end
    q1[0] = 9;
    q2[0] = 5;
    for (int k = 0; k < 8; k++)
      vz[k] = alu_m(q2[k], alu_m(q1[k], va2[k], vb2[k]),
                    vc2[k]);
    for (int e = 0; e < 10; e++) begin
      if (e < 8) begin
        iv2 = 1'b1;
        a2  = 8'(va2[e]);
        b2  = 8'(vb2[e]);
        c2  = 8'(vc2[e]);
        p1  = 4'(q1[e]);
        p2  = 4'(q2[e]);
      end else begin
        iv2 = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc_n++;
      chk("m1_rdy", 64'(ir2), 64'(1));
      if (e >= 2) begin
        chk("m1_ov", 64'(ov2), 64'(1));
        chk("m1_z", 64'(z2), 64'(vz[e-2]));
      end
      if (e == 2)
        chk("m1_oor_zero", 64'(z2), 64'(0));
    end
    @(posedge clk);
    #1;
    chk("m1_drain", 64'(ov2), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
